// File: rtl/seq_shifter_if.sv
// Handshake and data bundle for seq_shifter: request side (start, mode, a, b)
// and result side (y, zero, busy, done).
interface seq_shifter_if #(
  parameter int WIDTH = 4
) ();

  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             busy;
  logic             done;

  // Requester: issues operations and observes results.
  modport master (
    output start, mode, a, b,
    input  y, zero, busy, done
  );

  // Shifter: accepts operations and returns results.
  modport slave (
    input  start, mode, a, b,
    output y, zero, busy, done
  );

endinterface

// File: rtl/seq_shifter.sv
// Sequential barrel-less shifter: performs LSR/LSL/ASR/ROR one bit per clock.
// IDLE accepts a request, SHIFT walks the work register down a counter of
// effective shift steps, DONE publishes the result with a one-cycle pulse.
module seq_shifter #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  seq_shifter_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_LSR = 2'b00,
    MODE_LSL = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROR = 2'b11
  } mode_t;

  state_t           state;
  state_t           state_next;
  mode_t            mode_q;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_step;
  logic [WIDTH-1:0] y_q;
  logic             zero_q;
  logic [CW-1:0]    count;
  logic [CW-1:0]    eff_amt;
  logic [31:0]      b_ext;
  logic             busy_c;
  logic             done_c;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and status outputs.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves a value unassigned and infers a latch.
    state_next = state;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    unique case (state)
      IDLE:  if (bus.start) state_next = SHIFT;
      SHIFT: begin
        busy_c = 1'b1;
        if (count == '0) state_next = DONE;
      end
      DONE:  begin
        busy_c     = 1'b1;
        done_c     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Effective step count: saturate at WIDTH for shifts, wrap for rotate, so
  // the counter always fits in CW bits and only ever counts down to zero.
  always_comb begin
    b_ext = 32'(bus.b);
    if (bus.mode == MODE_ROR)  eff_amt = CW'(b_ext % WIDTH);
    else if (b_ext >= WIDTH)   eff_amt = CW'(WIDTH);
    else                       eff_amt = CW'(b_ext);
  end

  // One-bit step of the work register for the latched mode.
  always_comb begin
    work_step = work;
    unique case (mode_q)
      MODE_LSR: work_step = {1'b0, work[WIDTH-1:1]};
      MODE_LSL: work_step = {work[WIDTH-2:0], 1'b0};
      MODE_ASR: work_step = {work[WIDTH-1], work[WIDTH-1:1]};
      MODE_ROR: work_step = {work[0], work[WIDTH-1:1]};
      default:  work_step = work;
    endcase
  end

  // Datapath: load on accept, step while counting, publish on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      work   <= '0;
      count  <= '0;
      mode_q <= MODE_LSR;
      y_q    <= '0;
      zero_q <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            work   <= bus.a;
            mode_q <= mode_t'(bus.mode);
            count  <= eff_amt;
          end
        end
        SHIFT: begin
          if (count != '0) begin
            work  <= work_step;
            count <= count - CW'(1);
          end else begin
            y_q    <= work;
            zero_q <= (work == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.y    = y_q;
  assign bus.zero = zero_q;
  assign bus.busy = busy_c;
  assign bus.done = done_c;

endmodule
